// File: rtl/fpdiv_iterative.sv
// rtl/fpdiv_iterative.sv - iterative restoring signed fixed-point divider, c = a / b
// Define FPDIV_ROUND_EN to add a guard iteration and round half away from zero.
module fpdiv_iterative #(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           recv_val,
  output logic           recv_rdy,
  input  logic [2*n-1:0] recv_msg,
  output logic           send_val,
  input  logic           send_rdy,
  output logic [n-1:0]   send_msg
);
  localparam int W  = n + d;
`ifdef FPDIV_ROUND_EN
  localparam int QW = W + 1;
`else
  localparam int QW = W;
`endif
  localparam int MW = W + 1;
  localparam int CW = $clog2(n + d + 2);
  localparam logic [n-1:0]  MAX_POS = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0]  MIN_NEG = {1'b1, {(n-1){1'b0}}};
  localparam logic [MW-1:0] POS_LIM = MW'(MAX_POS);
  localparam logic [MW-1:0] NEG_LIM = MW'(MIN_NEG);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    div_q, div_d;
  logic [n:0]      rem_q, rem_d;
  logic [QW-1:0]   quot_q, quot_d;
  logic [n-1:0]    bmag_q, bmag_d;
  logic            sign_q, sign_d;
  logic            dbz_q, dbz_d;
  logic            aneg_q, aneg_d;
  logic [n-1:0]    result_q, result_d;

  logic [n-1:0]    op_a, op_b, a_mag, b_mag;
  logic [n+1:0]    rem_sh;
  logic            ge;
  logic [n:0]      rem_nxt;
  logic [QW-1:0]   quot_nxt;
  logic [MW-1:0]   mag;
  logic [n-1:0]    res_comb;
  logic            last_iter;

  assign op_a      = recv_msg[2*n-1:n];
  assign op_b      = recv_msg[n-1:0];
  assign a_mag     = op_a[n-1] ? -op_a : op_a;
  assign b_mag     = op_b[n-1] ? -op_b : op_b;
  assign last_iter = (cnt_q == CW'(QW - 1));

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign rem_sh   = {rem_q, div_q[W-1]};
  assign ge       = (rem_sh >= {2'b00, bmag_q});
  assign rem_nxt  = ge ? (rem_sh[n:0] - {1'b0, bmag_q}) : rem_sh[n:0];
  assign quot_nxt = {quot_q[QW-2:0], ge};

`ifdef FPDIV_ROUND_EN
  assign mag = {1'b0, quot_nxt[QW-1:1]} + MW'(quot_nxt[0]);
`else
  assign mag = {1'b0, quot_nxt};
`endif

  always_comb begin
    res_comb = '0;
    if (dbz_q)
      res_comb = aneg_q ? MIN_NEG : MAX_POS;
    else if (!sign_q && (mag > POS_LIM))
      res_comb = MAX_POS;
    else if (sign_q && (mag > NEG_LIM))
      res_comb = MIN_NEG;
    else
      res_comb = sign_q ? -mag[n-1:0] : mag[n-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (recv_val)  state_d = S_CALC;
      S_CALC:  if (last_iter) state_d = S_DONE;
      S_DONE:  if (send_rdy)  state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    recv_rdy = (state_q == S_IDLE);
    send_val = (state_q == S_DONE);
    send_msg = result_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    bmag_d   = bmag_q;
    sign_d   = sign_q;
    dbz_d    = dbz_q;
    aneg_d   = aneg_q;
    result_d = result_q;
    if (state_q == S_IDLE && recv_val) begin
      cnt_d  = '0;
      div_d  = W'(a_mag) << d;
      rem_d  = '0;
      quot_d = '0;
      bmag_d = b_mag;
      sign_d = op_a[n-1] ^ op_b[n-1];
      dbz_d  = (op_b == '0);
      aneg_d = op_a[n-1];
    end else if (state_q == S_CALC) begin
      cnt_d  = cnt_q + CW'(1);
      div_d  = {div_q[W-2:0], 1'b0};
      rem_d  = rem_nxt;
      quot_d = quot_nxt;
      if (last_iter) result_d = res_comb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      bmag_q   <= '0;
      sign_q   <= 1'b0;
      dbz_q    <= 1'b0;
      aneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      bmag_q   <= bmag_d;
      sign_q   <= sign_d;
      dbz_q    <= dbz_d;
      aneg_q   <= aneg_d;
      result_q <= result_d;
    end
  end

endmodule
